// File: rtl/user_flash_pkg.sv
// Shared definitions for the user flash writer/reader: FSM encoding, flash timing in ns
// and conversion of a duration into clock cycles.
package user_flash_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StNvs,
        StPgs,
        StProg,
        StPgh,
        StErs,
        StNvh,
        StRcv,
        StDone
    } flash_state_e;

    // 25 bits covers Terase (100 ms) at clocks up to 200 MHz.
    localparam int unsigned CntWidth = 25;

    localparam longint unsigned TNvsNs   = 64'd5_000;
    localparam longint unsigned TPgsNs   = 64'd10_000;
    localparam longint unsigned TProgNs  = 64'd16_000;
    localparam longint unsigned TPghNs   = 64'd20;
    localparam longint unsigned TNvhNs   = 64'd5_000;
    localparam longint unsigned TNvh1Ns  = 64'd100_000;
    localparam longint unsigned TRcvNs   = 64'd10_000;
    localparam longint unsigned TEraseNs = 64'd100_000_000;

    // ceil(t_ns * clk_freq / 1e9), never less than one cycle.
    function automatic logic [CntWidth-1:0] ns_to_cycles(input longint unsigned t_ns,
                                                         input longint unsigned clk_freq);
        longint unsigned c;
        c = (t_ns * clk_freq + 64'd999_999_999) / 64'd1_000_000_000;
        if (c == 64'd0) begin
            c = 64'd1;
        end
        return c[CntWidth-1:0];
    endfunction

endpackage

// File: rtl/flash_delay_timer.sv
// Loadable down-counter pacing flash phases; done is high during the last cycle of a phase.
module flash_delay_timer
    import user_flash_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [CntWidth-1:0] value,
    input  logic                count,
    output logic                done
);

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (count && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    assign done = (cnt_q == CntWidth'(1));

endmodule

// File: rtl/user_flash_writer.sv
// Sequences word program and page erase on the user flash primitive; all primitive controls
// are registered and the reader shares the primitive by watching busy.
module user_flash_writer
    import user_flash_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 27_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        select,
    input  logic [3:0]  wstrb,
    input  logic [14:0] addr,
    input  logic [31:0] data_i,
    input  logic        page_erase,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic        xe,
    output logic        ye,
    output logic        se,
    output logic        prog,
    output logic        erase,
    output logic        nvstr,
    output logic [8:0]  xadr,
    output logic [5:0]  yadr,
    output logic [31:0] din
);

    localparam longint unsigned Freq = 64'(CLK_FREQ);

    localparam logic [CntWidth-1:0] CNvs   = ns_to_cycles(TNvsNs, Freq);
    localparam logic [CntWidth-1:0] CPgs   = ns_to_cycles(TPgsNs, Freq);
    localparam logic [CntWidth-1:0] CProg  = ns_to_cycles(TProgNs, Freq);
    localparam logic [CntWidth-1:0] CPgh   = ns_to_cycles(TPghNs, Freq);
    localparam logic [CntWidth-1:0] CNvh   = ns_to_cycles(TNvhNs, Freq);
    localparam logic [CntWidth-1:0] CNvh1  = ns_to_cycles(TNvh1Ns, Freq);
    localparam logic [CntWidth-1:0] CRcv   = ns_to_cycles(TRcvNs, Freq);
    localparam logic [CntWidth-1:0] CErase = ns_to_cycles(TEraseNs, Freq);

    flash_state_e        state;
    logic [5:0]          col_q;
    logic [31:0]         data_q;
    logic                erase_q;
    logic                req_ok;
    logic                tmr_load;
    logic                tmr_count;
    logic                tmr_done;
    logic [CntWidth-1:0] tmr_value;

    // Erase ignores wstrb; a program must write the full word.
    assign req_ok = page_erase || (wstrb == 4'hF);
    assign se     = 1'b0;

    flash_delay_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .value   (tmr_value),
        .count   (tmr_count),
        .done    (tmr_done)
    );

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        tmr_count = (state != StIdle) && (state != StDone);
        case (state)
            StIdle: begin
                tmr_load  = select && req_ok;
                tmr_value = CNvs;
            end
            StNvs: begin
                tmr_load  = tmr_done;
                tmr_value = erase_q ? CErase : CPgs;
            end
            StPgs: begin
                tmr_load  = tmr_done;
                tmr_value = CProg;
            end
            StProg: begin
                tmr_load  = tmr_done;
                tmr_value = CPgh;
            end
            StPgh: begin
                tmr_load  = tmr_done;
                tmr_value = CNvh;
            end
            StErs: begin
                tmr_load  = tmr_done;
                tmr_value = CNvh1;
            end
            StNvh: begin
                tmr_load  = tmr_done;
                tmr_value = CRcv;
            end
            default: begin
                tmr_load  = 1'b0;
                tmr_value = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= StIdle;
            col_q   <= '0;
            data_q  <= '0;
            erase_q <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            xe      <= 1'b0;
            ye      <= 1'b0;
            prog    <= 1'b0;
            erase   <= 1'b0;
            nvstr   <= 1'b0;
            xadr    <= '0;
            yadr    <= '0;
            din     <= '0;
        end else begin
            ready <= 1'b0;
            case (state)
                StIdle: begin
                    if (select) begin
                        col_q   <= addr[5:0];
                        data_q  <= data_i;
                        erase_q <= page_erase;
                        if (req_ok) begin
                            state <= StNvs;
                            busy  <= 1'b1;
                            err   <= 1'b0;
                            xe    <= 1'b1;
                            prog  <= !page_erase;
                            erase <= page_erase;
                            xadr  <= addr[14:6];
                        end else begin
                            state <= StDone;
                            ready <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                StNvs: begin
                    if (tmr_done) begin
                        nvstr <= 1'b1;
                        state <= erase_q ? StErs : StPgs;
                    end
                end
                StPgs: begin
                    if (tmr_done) begin
                        ye    <= 1'b1;
                        yadr  <= col_q;
                        din   <= data_q;
                        state <= StProg;
                    end
                end
                StProg: begin
                    if (tmr_done) begin
                        ye    <= 1'b0;
                        state <= StPgh;
                    end
                end
                StPgh: begin
                    if (tmr_done) begin
                        prog  <= 1'b0;
                        state <= StNvh;
                    end
                end
                StErs: begin
                    if (tmr_done) begin
                        erase <= 1'b0;
                        state <= StNvh;
                    end
                end
                StNvh: begin
                    if (tmr_done) begin
                        nvstr <= 1'b0;
                        state <= StRcv;
                    end
                end
                StRcv: begin
                    if (tmr_done) begin
                        xe    <= 1'b0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        err   <= 1'b0;
                        xadr  <= '0;
                        yadr  <= '0;
                        din   <= '0;
                        state <= StDone;
                    end
                end
                StDone: begin
                    err   <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_user_flash_writer.sv
// Directed and randomized bench for user_flash_writer: one instance at 27 MHz, one at a slow
// clock so a full page erase fits a short run.
module tb_user_flash_writer;

    localparam int unsigned FreqP = 27_000_000;
    localparam int unsigned FreqE = 100_000;
    localparam int XE = 0, YE = 1, SE = 2, PROG = 3, ERASE = 4, NVSTR = 5, RDY = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sel_p, sel_e;
    logic [3:0]  wstrb;
    logic [14:0] addr;
    logic [31:0] data_i;
    logic        page_erase;

    logic        p_ready, p_err, p_busy, p_xe, p_ye, p_se, p_prog, p_erase, p_nvstr;
    logic [8:0]  p_xadr;
    logic [5:0]  p_yadr;
    logic [31:0] p_din;
    logic        e_ready, e_err, e_busy, e_xe, e_ye, e_se, e_prog, e_erase, e_nvstr;
    logic [8:0]  e_xadr;
    logic [5:0]  e_yadr;
    logic [31:0] e_din;

    always #5 clk = ~clk;

    user_flash_writer #(.CLK_FREQ(FreqP)) dut_p (
        .clk(clk), .reset_n(reset_n), .select(sel_p), .wstrb(wstrb), .addr(addr),
        .data_i(data_i), .page_erase(page_erase), .ready(p_ready), .err(p_err), .busy(p_busy),
        .xe(p_xe), .ye(p_ye), .se(p_se), .prog(p_prog), .erase(p_erase), .nvstr(p_nvstr),
        .xadr(p_xadr), .yadr(p_yadr), .din(p_din)
    );

    user_flash_writer #(.CLK_FREQ(FreqE)) dut_e (
        .clk(clk), .reset_n(reset_n), .select(sel_e), .wstrb(wstrb), .addr(addr),
        .data_i(data_i), .page_erase(page_erase), .ready(e_ready), .err(e_err), .busy(e_busy),
        .xe(e_xe), .ye(e_ye), .se(e_se), .prog(e_prog), .erase(e_erase), .nvstr(e_nvstr),
        .xadr(e_xadr), .yadr(e_yadr), .din(e_din)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference timing: ceil(t * f) cycles with a floor of one.
    function automatic int ref_cycles(input longint t_ns, input longint f);
        longint p, q;
        p = t_ns * f;
        q = p / longint'(1_000_000_000);
        if (p % longint'(1_000_000_000) != 0) q = q + 1;
        if (q < 1) q = 1;
        return int'(q);
    endfunction

    int m_nvs, m_pgs, m_prog, m_pgh, m_nvh, m_nvh1, m_rcv, m_ers;

    task automatic set_model(input bit which);
        longint f;
        f = which ? longint'(FreqE) : longint'(FreqP);
        m_nvs  = ref_cycles(5_000, f);
        m_pgs  = ref_cycles(10_000, f);
        m_prog = ref_cycles(16_000, f);
        m_pgh  = ref_cycles(20, f);
        m_nvh  = ref_cycles(5_000, f);
        m_nvh1 = ref_cycles(100_000, f);
        m_rcv  = ref_cycles(10_000, f);
        m_ers  = ref_cycles(100_000_000, f);
    endtask

    function automatic logic [6:0] vec(input bit which);
        return which ? {e_ready, e_nvstr, e_erase, e_prog, e_se, e_ye, e_xe}
                     : {p_ready, p_nvstr, p_erase, p_prog, p_se, p_ye, p_xe};
    endfunction

    int          rise_at[7];
    int          fall_at[7];
    logic [8:0]  xadr_x;
    logic [5:0]  yadr_y;
    logic [31:0] din_y;
    logic        err_r, busy_0;
    bit          stable_bad, timed_out;

    task automatic start(input bit which, input logic [14:0] a, input logic [31:0] d,
                         input logic [3:0] ws, input logic pe);
        @(negedge clk);
        addr = a;
        data_i = d;
        wstrb = ws;
        page_erase = pe;
        if (which) sel_e = 1'b1;
        else sel_p = 1'b1;
        @(posedge clk);
    endtask

    // Records rise/fall cycle of each control relative to the first cycle after acceptance.
    task automatic capture(input bit which, input int resel_at, input logic [14:0] alt_a,
                           input logic [31:0] alt_d, input int limit);
        logic [6:0]  v, pv;
        logic [8:0]  xa;
        logic [5:0]  ya;
        logic [31:0] dn;
        pv = '0;
        stable_bad = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rise_at[i] = -1;
            fall_at[i] = -1;
        end
        for (int rel = 0; rel < limit && timed_out; rel++) begin
            @(negedge clk);
            if (rel == 0) begin
                sel_p = 1'b0;
                sel_e = 1'b0;
                busy_0 = which ? e_busy : p_busy;
            end
            if (rel == resel_at) begin
                addr = alt_a;
                data_i = alt_d;
                if (which) sel_e = 1'b1;
                else sel_p = 1'b1;
            end
            v  = vec(which);
            xa = which ? e_xadr : p_xadr;
            ya = which ? e_yadr : p_yadr;
            dn = which ? e_din : p_din;
            for (int i = 0; i < 7; i++) begin
                if (v[i] && !pv[i] && rise_at[i] < 0) rise_at[i] = rel;
                if (!v[i] && pv[i] && fall_at[i] < 0) fall_at[i] = rel;
            end
            if (v[XE] && !pv[XE]) xadr_x = xa;
            else if (v[XE] && xa != xadr_x) stable_bad = 1'b1;
            if (v[YE] && !pv[YE]) begin
                yadr_y = ya;
                din_y = dn;
            end else if (v[YE] && (ya != yadr_y || dn != din_y)) begin
                stable_bad = 1'b1;
            end
            if (v[RDY] && !pv[RDY]) err_r = which ? e_err : p_err;
            if (fall_at[RDY] >= 0) timed_out = 1'b0;
            pv = v;
        end
        check("capture_timeout", 32'(timed_out), 32'd0);
    endtask

    function automatic int prog_limit();
        return m_nvs + m_pgs + m_prog + m_pgh + m_nvh + m_rcv + 8;
    endfunction

    task automatic check_program(input bit which, input logic [14:0] a, input logic [31:0] d,
                                 input string pfx);
        set_model(which);
        check({pfx, "_xe_rise"}, rise_at[XE], 0);
        check({pfx, "_prog_rise"}, rise_at[PROG], 0);
        check({pfx, "_busy"}, 32'(busy_0), 32'd1);
        check({pfx, "_nvstr_rise"}, rise_at[NVSTR], m_nvs);
        check({pfx, "_ye_rise"}, rise_at[YE], m_nvs + m_pgs);
        check({pfx, "_ye_width"}, fall_at[YE] - rise_at[YE], m_prog);
        check({pfx, "_prog_fall"}, fall_at[PROG] - fall_at[YE], m_pgh);
        check({pfx, "_nvstr_fall"}, fall_at[NVSTR] - fall_at[PROG], m_nvh);
        check({pfx, "_xe_fall"}, fall_at[XE] - fall_at[NVSTR], m_rcv);
        check({pfx, "_ready_at"}, rise_at[RDY], fall_at[XE]);
        check({pfx, "_ready_width"}, fall_at[RDY] - rise_at[RDY], 1);
        check({pfx, "_err"}, 32'(err_r), 32'd0);
        check({pfx, "_no_erase"}, rise_at[ERASE], -1);
        check({pfx, "_xadr"}, 32'(xadr_x), 32'(a[14:6]));
        check({pfx, "_yadr"}, 32'(yadr_y), 32'(a[5:0]));
        check({pfx, "_din"}, din_y, d);
        check({pfx, "_stable"}, 32'(stable_bad), 32'd0);
    endtask

    task automatic check_erase(input bit which, input logic [8:0] row, input string pfx);
        set_model(which);
        check({pfx, "_erase_rise"}, rise_at[ERASE], 0);
        check({pfx, "_xe_rise"}, rise_at[XE], 0);
        check({pfx, "_nvstr_rise"}, rise_at[NVSTR], m_nvs);
        check({pfx, "_ers_width"}, fall_at[ERASE] - rise_at[NVSTR], m_ers);
        check({pfx, "_nvh1"}, fall_at[NVSTR] - fall_at[ERASE], m_nvh1);
        check({pfx, "_xe_fall"}, fall_at[XE] - fall_at[NVSTR], m_rcv);
        check({pfx, "_ready_at"}, rise_at[RDY], fall_at[XE]);
        check({pfx, "_ready_width"}, fall_at[RDY] - rise_at[RDY], 1);
        check({pfx, "_err"}, 32'(err_r), 32'd0);
        check({pfx, "_no_ye"}, rise_at[YE], -1);
        check({pfx, "_no_prog"}, rise_at[PROG], -1);
        check({pfx, "_xadr"}, 32'(xadr_x), 32'(row));
        check({pfx, "_stable"}, 32'(stable_bad), 32'd0);
    endtask

    task automatic check_reject(input string pfx);
        bit any;
        any = rise_at[XE] >= 0 || rise_at[YE] >= 0 || rise_at[PROG] >= 0 ||
              rise_at[ERASE] >= 0 || rise_at[NVSTR] >= 0;
        check({pfx, "_ready_at"}, rise_at[RDY], 0);
        check({pfx, "_ready_width"}, fall_at[RDY] - rise_at[RDY], 1);
        check({pfx, "_err"}, 32'(err_r), 32'd1);
        check({pfx, "_no_ctrl"}, 32'(any), 32'd0);
    endtask

    // Continuous protocol checks on both instances.
    logic nvp_p = 1'b0;
    logic nvp_e = 1'b0;
    always @(negedge clk) begin
        check("se_p", 32'(p_se), 32'd0);
        check("se_e", 32'(e_se), 32'd0);
        if (p_nvstr && !nvp_p) check("nvstr_rise_p", 32'(p_prog | p_erase), 32'd1);
        if (e_nvstr && !nvp_e) check("nvstr_rise_e", 32'(e_prog | e_erase), 32'd1);
        if (p_ye) check("ye_gate_p", 32'(p_prog & p_nvstr), 32'd1);
        if (e_ye) check("ye_gate_e", 32'(e_prog & e_nvstr), 32'd1);
        nvp_p <= p_nvstr;
        nvp_e <= e_nvstr;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] a, a2;
        logic [31:0] d, d2;
        logic [3:0]  ws;
        bit          found, seen;

        reset_n = 1'b0;
        sel_p = 1'b0;
        sel_e = 1'b0;
        wstrb = 4'h0;
        addr = '0;
        data_i = '0;
        page_erase = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl_p", 32'({p_ready, p_err, p_busy, p_xe, p_ye, p_se, p_prog, p_erase,
                                 p_nvstr}), 32'd0);
        check("rst_bus_p", 32'({p_xadr, p_yadr}) | p_din, 32'd0);
        check("rst_ctrl_e", 32'({e_ready, e_err, e_busy, e_xe, e_ye, e_se, e_prog, e_erase,
                                 e_nvstr}), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed program at 27 MHz.
        set_model(1'b0);
        start(1'b0, 15'h0041, 32'hDEADBEEF, 4'hF, 1'b0);
        capture(1'b0, -1, '0, '0, prog_limit());
        check_program(1'b0, 15'h0041, 32'hDEADBEEF, "prog41");
        check("prog41_nvs_135", rise_at[NVSTR] - rise_at[PROG], 135);
        check("prog41_ye_432", fall_at[YE] - rise_at[YE], 432);

        // Partial strobe is rejected immediately.
        start(1'b0, 15'h0123, 32'h0BADF00D, 4'b0011, 1'b0);
        capture(1'b0, -1, '0, '0, 8);
        check_reject("wstrb3");

        // Second select during PROG is ignored until the first completes.
        set_model(1'b0);
        a = 15'h1A2B;
        d = 32'hCAFEF00D;
        a2 = 15'h0567;
        d2 = 32'h13572468;
        start(1'b0, a, d, 4'hF, 1'b0);
        capture(1'b0, m_nvs + m_pgs + 5, a2, d2, prog_limit());
        check_program(1'b0, a, d, "first");
        check("second_not_in_done", 32'({p_busy, p_prog}), 32'd0);
        @(posedge clk);
        capture(1'b0, -1, '0, '0, prog_limit());
        check_program(1'b0, a2, d2, "second");

        // Full page erase on the slow instance, row 5.
        set_model(1'b1);
        start(1'b1, {9'd5, 6'($urandom)}, $urandom, 4'($urandom), 1'b1);
        capture(1'b1, -1, '0, '0, m_nvs + m_ers + m_nvh1 + m_rcv + 8);
        check_erase(1'b1, 9'd5, "erase5");

        // Reset asserted in the middle of ERS.
        set_model(1'b0);
        start(1'b0, {9'd7, 6'd9}, 32'h00001234, 4'h3, 1'b1);
        @(negedge clk);
        sel_p = 1'b0;
        found = 1'b0;
        for (int i = 0; i < m_nvs + 20 && !found; i++) begin
            if (p_erase && p_nvstr) found = 1'b1;
            else @(negedge clk);
        end
        check("ers_reached", 32'(found), 32'd1);
        repeat (37) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_ers_ctrl", 32'({p_ready, p_err, p_busy, p_xe, p_ye, p_se, p_prog, p_erase,
                                   p_nvstr}), 32'd0);
        check("rst_ers_bus", 32'({p_xadr, p_yadr}) | p_din, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (p_ready) seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (p_ready || p_busy) seen = 1'b1;
        end
        check("rst_no_ready", 32'(seen), 32'd0);
        start(1'b0, 15'h7FC0, 32'hA5A5_5A5A, 4'hF, 1'b0);
        capture(1'b0, -1, '0, '0, prog_limit());
        check_program(1'b0, 15'h7FC0, 32'hA5A5_5A5A, "post_rst");

        // Randomized programs and rejects at 27 MHz.
        for (int k = 0; k < 5; k++) begin
            a = 15'($urandom);
            d = $urandom;
            start(1'b0, a, d, 4'hF, 1'b0);
            capture(1'b0, -1, '0, '0, prog_limit());
            check_program(1'b0, a, d, "rnd_prog");
            ws = 4'($urandom_range(0, 14));
            start(1'b0, a, d, ws, 1'b0);
            capture(1'b0, -1, '0, '0, 8);
            check_reject("rnd_rej");
        end

        // Randomized programs on the slow instance, where several phases clamp to one cycle.
        set_model(1'b1);
        for (int k = 0; k < 4; k++) begin
            a = 15'($urandom);
            d = $urandom;
            start(1'b1, a, d, 4'hF, 1'b0);
            capture(1'b1, -1, '0, '0, prog_limit());
            check_program(1'b1, a, d, "slow_prog");
        end

        // Erase at a random row with random strobes.
        a = 15'($urandom);
        start(1'b1, a, $urandom, 4'($urandom), 1'b1);
        capture(1'b1, -1, '0, '0, m_nvs + m_ers + m_nvh1 + m_rcv + 8);
        check_erase(1'b1, a[14:6], "rnd_erase");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
